// File: rtl/knight_anim_addr_gen_if.sv
// -----------------------------------------------------------------------------
// knight_anim_addr_gen_if
// Bundles the pixel-scan inputs, the knight pose/physics inputs and the sprite
// ROM lookup outputs of knight_anim_addr_gen.
//   DrawX, DrawY        : current pixel coordinates (10 bits each)
//   blank               : high while the pixel is in the visible region
//   knight_x, knight_y  : sprite top-left corner (10 bits each)
//   facing_left         : mirror the sprite horizontally
//   jump_req            : level request to start a jump
//   on_ground           : physics reports the knight has landed
//   rom_address         : 14-bit sprite ROM word address
//   sprite_hit          : pixel lies inside the visible sprite box
//   anim_state          : 00 IDLE, 01 JUMP_RISE, 10 JUMP_FALL
// master drives the inputs (video/physics side), slave is the generator.
// -----------------------------------------------------------------------------
interface knight_anim_addr_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [9:0]  knight_x;
  logic [9:0]  knight_y;
  logic        facing_left;
  logic        jump_req;
  logic        on_ground;
  logic [13:0] rom_address;
  logic        sprite_hit;
  logic [1:0]  anim_state;

  modport master (
    output DrawX, DrawY, blank, knight_x, knight_y, facing_left, jump_req, on_ground,
    input  rom_address, sprite_hit, anim_state
  );

  modport slave (
    input  DrawX, DrawY, blank, knight_x, knight_y, facing_left, jump_req, on_ground,
    output rom_address, sprite_hit, anim_state
  );
endinterface

// File: rtl/knight_anim_addr_gen.sv
// -----------------------------------------------------------------------------
// knight_anim_addr_gen
// Generates the sprite ROM address for the knight character and runs its
// jump animation (IDLE -> JUMP_RISE -> JUMP_FALL -> IDLE). The animation only
// advances once per display frame, on the last visible pixel (639,479).
// Ports:
//   vga_clk : single clock for all logic
//   reset_n : asynchronous active-low reset
//   bus     : knight_anim_addr_gen_if.slave (pixel, pose, physics, ROM outputs)
// rom_address / sprite_hit are registered: one vga_clk after the pixel.
// -----------------------------------------------------------------------------
module knight_anim_addr_gen #(
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 64,
  parameter int RISE_FRAMES = 16,
  parameter int HOLD        = 6
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  knight_anim_addr_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RISE = 2'b01,
    ST_FALL = 2'b10
  } state_e;

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int RISE_W = (RISE_FRAMES > 1) ? $clog2(RISE_FRAMES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD - 1);
  localparam logic [RISE_W-1:0] RISE_LAST   = RISE_W'(RISE_FRAMES - 1);
  localparam logic [13:0]       FRAME_WORDS = 14'(SPR_W * SPR_H);
  localparam logic [13:0]       ROW_WORDS   = 14'(SPR_W);
  localparam logic [13:0]       COL_LAST    = 14'(SPR_W - 1);
  localparam logic [10:0]       X_SPAN      = 11'(SPR_W);
  localparam logic [10:0]       Y_SPAN      = 11'(SPR_H);

  // Advance the frame index by one, holding it once it reaches limit.
  function automatic logic [1:0] frame_inc_sat(input logic [1:0] frame, input logic [1:0] limit);
    logic [1:0] nxt;
    if (frame >= limit) begin
      nxt = limit;
    end else begin
      nxt = frame + 2'd1;
    end
    return nxt;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          frame_q, frame_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [RISE_W-1:0]   rise_q, rise_d;
  logic                sprite_hit_q, sprite_hit_d;
  logic [13:0]         rom_address_q, rom_address_d;

  logic                frame_tick_s;
  logic                in_box_s;
  logic [9:0]          lx_s;
  logic [9:0]          ly_s;
  logic [13:0]         col_s;
  logic [10:0]         x_end_s;
  logic [10:0]         y_end_s;

  assign frame_tick_s = (bus.DrawX == 10'd639) && (bus.DrawY == 10'd479);

  // Animation state register and counters.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      frame_q <= 2'd0;
      hold_q  <= '0;
      rise_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      rise_q  <= rise_d;
    end
  end

  // Next animation state; everything holds except on the frame tick.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    rise_d  = rise_q;
    if (frame_tick_s) begin
      case (state_q)
        ST_IDLE: begin
          frame_d = 2'd0;
          hold_d  = '0;
          rise_d  = '0;
          if (bus.jump_req) begin
            state_d = ST_RISE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RISE: begin
          // The end of the rise overrides any hold-count frame advance.
          if (rise_q == RISE_LAST) begin
            state_d = ST_FALL;
            frame_d = 2'd2;
            hold_d  = '0;
            rise_d  = '0;
          end else begin
            rise_d = rise_q + RISE_W'(1);
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              frame_d = frame_inc_sat(frame_q, 2'd1);
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        ST_FALL: begin
          // Landing wins over the hold-count advance.
          if (bus.on_ground) begin
            state_d = ST_IDLE;
            frame_d = 2'd0;
            hold_d  = '0;
            rise_d  = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            frame_d = frame_inc_sat(frame_q, 2'd3);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          frame_d = 2'd0;
          hold_d  = '0;
          rise_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      rise_d  = rise_q;
    end
  end

  // Sprite box test and ROM address for the current pixel.
  always_comb begin
    // 11-bit ends so a box hanging past x/y=1023 does not wrap to small values.
    x_end_s  = {1'b0, bus.knight_x} + X_SPAN;
    y_end_s  = {1'b0, bus.knight_y} + Y_SPAN;
    in_box_s = (bus.DrawX >= bus.knight_x) && ({1'b0, bus.DrawX} < x_end_s) &&
               (bus.DrawY >= bus.knight_y) && ({1'b0, bus.DrawY} < y_end_s);
    lx_s     = bus.DrawX - bus.knight_x;
    ly_s     = bus.DrawY - bus.knight_y;
    if (bus.facing_left) begin
      col_s = COL_LAST - {4'd0, lx_s};
    end else begin
      col_s = {4'd0, lx_s};
    end
    sprite_hit_d = in_box_s && bus.blank;
    if (sprite_hit_d) begin
      rom_address_d = ({12'd0, frame_q} * FRAME_WORDS) + ({4'd0, ly_s} * ROW_WORDS) + col_s;
    end else begin
      rom_address_d = 14'd0;
    end
  end

  // Output registers: one vga_clk behind DrawX/DrawY.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_hit_q  <= 1'b0;
      rom_address_q <= 14'd0;
    end else begin
      sprite_hit_q  <= sprite_hit_d;
      rom_address_q <= rom_address_d;
    end
  end

  assign bus.sprite_hit  = sprite_hit_q;
  assign bus.rom_address = rom_address_q;
  assign bus.anim_state  = state_q;

endmodule
